// File: rtl/sync_fifo_flags.sv
// Parametrised synchronous FIFO (any depth) with occupancy, almost-full/empty
// thresholds, sticky error flags and flush. Define FIFO_EDGE_TRIG_EN for edge-triggered strobes.
module sync_fifo_flags #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned AF_LEVEL   = DEPTH - 2,
   parameter int unsigned AE_LEVEL   = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    clear_err,
   input  logic                    write_en,
   input  logic                    read_en,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr_nxt;
   logic [PTR_W-1:0]      rd_ptr_nxt;
   logic                  wr_req;
   logic                  rd_req;
   logic                  wr_acc;
   logic                  rd_acc;

`ifdef FIFO_EDGE_TRIG_EN
   logic write_en_d;
   logic read_en_d;

   // History resets high so a strobe held through reset release is not taken
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_en_d <= 1'b1;
         read_en_d  <= 1'b1;
      end else begin
         write_en_d <= write_en;
         read_en_d  <= read_en;
      end
   end

   assign wr_req = write_en & ~write_en_d;
   assign rd_req = read_en  & ~read_en_d;
`else
   assign wr_req = write_en;
   assign rd_req = read_en;
`endif

   // Status flags decode only the registered count
   assign full         = (count == CNT_W'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (32'(count) >= AF_LEVEL);
   assign almost_empty = (32'(count) <= AE_LEVEL);

   // Acceptance uses pre-edge full/empty; flush overrides both
   assign wr_acc = wr_req & ~full  & ~flush;
   assign rd_acc = rd_req & ~empty & ~flush;

   assign wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
   assign rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);

   assign data_out = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (wr_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr_nxt;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr_nxt;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // A new error in the same cycle as clear_err wins
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  & ~clear_err) | (wr_req & full  & ~flush);
         underflow <= (underflow & ~clear_err) | (rd_req & empty & ~flush);
      end
   end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed, table-driven bench for sync_fifo_flags (DEPTH=5, AF=3, AE=2).
// Edge-strobe sequences run instead of the level table when FIFO_EDGE_TRIG_EN is defined.
`timescale 1ns/1ps
module tb_sync_fifo_flags;

   localparam int unsigned DW = 8;
   localparam int unsigned DP = 5;

   logic          clock;
   logic          reset;
   logic          flush;
   logic          clear_err;
   logic          write_en;
   logic          read_en;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic [3:0]    count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow;
   logic          underflow;

   int n_vec;
   int n_err;

   typedef struct {
      logic       fl;
      logic       ce;
      logic       wr;
      logic       rd;
      logic [7:0] din;
      int         cnt;
      logic       ovf;
      logic       unf;
      logic [7:0] dout;
      logic       cd;
   } vec_t;

   vec_t vq[$];

   sync_fifo_flags #(
      .DATA_WIDTH (DW),
      .DEPTH      (DP)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .clear_err    (clear_err),
      .write_en     (write_en),
      .read_en      (read_en),
      .data_in      (data_in),
      .data_out     (data_out),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void add(input logic fl, input logic ce, input logic wr, input logic rd,
                               input logic [7:0] din, input int cnt, input logic ovf,
                               input logic unf, input logic [7:0] dout, input logic cd);
      vec_t v;
      v.fl = fl; v.ce = ce; v.wr = wr; v.rd = rd; v.din = din;
      v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.dout = dout; v.cd = cd;
      vq.push_back(v);
   endfunction

   // Flags are derived from the expected count using the bench's own thresholds
   task automatic check(input string name, input int cnt, input logic ovf, input logic unf,
                        input logic [7:0] dout, input logic cd);
      logic [9:0] act;
      logic [9:0] exp;
      act = {count, full, empty, almost_full, almost_empty, overflow, underflow};
      exp = {4'(cnt), 1'(cnt == 5), 1'(cnt == 0), 1'(cnt >= 3), 1'(cnt <= 2), ovf, unf};
      n_vec++;
      if (act !== exp || (cd && data_out !== dout)) begin
         n_err++;
         $display("FAIL %s: got cnt=%0d f=%b e=%b af=%b ae=%b ovf=%b unf=%b dout=%h, expected cnt=%0d f=%b e=%b af=%b ae=%b ovf=%b unf=%b dout=%h(chk=%b)",
                  name, act[9:6], act[5], act[4], act[3], act[2], act[1], act[0], data_out,
                  exp[9:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0], dout, cd);
      end
   endtask

   task automatic step(input logic fl, input logic ce, input logic wr, input logic rd,
                       input logic [7:0] din);
      @(negedge clock);
      flush = fl; clear_err = ce; write_en = wr; read_en = rd; data_in = din;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      @(negedge clock);
      flush = 1'b0; clear_err = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1; flush = 1'b0; clear_err = 1'b0; data_in = '0; read_en = 1'b0;
`ifdef FIFO_EDGE_TRIG_EN
      write_en = 1'b1;
`else
      write_en = 1'b0;
`endif
      repeat (2) @(posedge clock);
      #1;
      check("reset", 0, 1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge clock);
      reset = 1'b0;

`ifdef FIFO_EDGE_TRIG_EN
      // write_en held through reset release: no request
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
      check("edge_held_thru_reset", 0, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
      check("edge_held_4", 1, 1'b0, 1'b0, 8'h3C, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      check("edge_read_held", 0, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      check("edge_underflow", 0, 1'b0, 1'b1, 8'h00, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      check("edge_clear_held_rd", 0, 1'b0, 1'b0, 8'h00, 1'b0);
      idle_inputs();
`else
      // Fill to full, then overflow
      add(0,0,1,0,8'h11, 1,0,0,8'h11,1);
      add(0,0,1,0,8'h12, 2,0,0,8'h11,1);
      add(0,0,1,0,8'h13, 3,0,0,8'h11,1);
      add(0,0,1,0,8'h14, 4,0,0,8'h11,1);
      add(0,0,1,0,8'h15, 5,0,0,8'h11,1);
      add(0,0,1,0,8'h16, 5,1,0,8'h11,1);
      // Drain in order, then underflow and clear
      add(0,0,0,1,8'h00, 4,1,0,8'h12,1);
      add(0,0,0,1,8'h00, 3,1,0,8'h13,1);
      add(0,0,0,1,8'h00, 2,1,0,8'h14,1);
      add(0,0,0,1,8'h00, 1,1,0,8'h15,1);
      add(0,0,0,1,8'h00, 0,1,0,8'h00,0);
      add(0,0,0,1,8'h00, 0,1,1,8'h00,0);
      add(0,1,0,0,8'h00, 0,0,0,8'h00,0);
      // Simultaneous write/read at count 2 across several pointer wraps
      add(0,0,1,0,8'h21, 1,0,0,8'h21,1);
      add(0,0,1,0,8'h22, 2,0,0,8'h21,1);
      for (int k = 1; k <= 12; k++) begin
         add(0,0,1,1,8'(8'h22 + k), 2,0,0,8'(8'h21 + k),1);
      end
      add(0,0,0,1,8'h00, 1,0,0,8'h2E,1);
      add(0,0,0,1,8'h00, 0,0,0,8'h00,0);
      // Write+read into empty: read rejected
      add(0,0,1,1,8'hA5, 1,0,1,8'hA5,1);
      add(0,1,0,0,8'h00, 1,0,0,8'hA5,1);
      add(0,0,1,0,8'h01, 2,0,0,8'hA5,1);
      add(0,0,1,0,8'h02, 3,0,0,8'hA5,1);
      // Flush beats write/read and sets no error
      add(1,0,1,0,8'h99, 0,0,0,8'h00,0);
      add(1,0,0,1,8'h00, 0,0,0,8'h00,0);
      // New error in the same cycle as clear_err keeps the flag
      add(0,0,0,1,8'h00, 0,0,1,8'h00,0);
      add(0,1,0,1,8'h00, 0,0,1,8'h00,0);
      add(0,1,0,0,8'h00, 0,0,0,8'h00,0);
      add(0,0,1,0,8'h77, 1,0,0,8'h77,1);

      foreach (vq[i]) begin
         step(vq[i].fl, vq[i].ce, vq[i].wr, vq[i].rd, vq[i].din);
         check($sformatf("vec%0d", i), vq[i].cnt, vq[i].ovf, vq[i].unf, vq[i].dout, vq[i].cd);
      end
      idle_inputs();

      // Strobes mid-cycle must not move any flag before the edge
      #1;
      write_en = 1'b1; read_en = 1'b1; data_in = 8'h55;
      #1;
      check("no_comb_path", 1, 1'b0, 1'b0, 8'h77, 1'b1);
      write_en = 1'b0; read_en = 1'b0;
`endif

      // Asynchronous reset mid-cycle, away from any clock edge
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", 0, 1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("post_reset_idle", 0, 1'b0, 1'b0, 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
